// File: rtl/penalty_referee.sv
// Penalty-shootout scorekeeper: alternates kicks between team A and team B
// over a 3- or 5-round regulation, ends early once the result is settled,
// then runs sudden-death rounds until one kick in a round differs.
//
// state  | meaning
// IDLE   | no game yet; waiting for a start pulse
// PLAY_A | regulation, team A to kick
// PLAY_B | regulation, team B to kick
// SD_A   | sudden death, team A to kick
// SD_B   | sudden death, team B to kick; this kick settles or continues
// DONE   | result held until the next valid start pulse
module penalty_referee #(
    parameter int SCORE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start3_i,
    input  logic               start5_i,
    input  logic               kick_i,
    input  logic               goal_i,
    output logic [SCORE_W-1:0] score_a_o,
    output logic [SCORE_W-1:0] score_b_o,
    output logic               turn_o,
    output logic [SCORE_W-1:0] round_o,
    output logic               sudden_o,
    output logic               game_over_o,
    output logic [1:0]         winner_o
);

    localparam int W1 = SCORE_W + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PLAY_A = 3'd1,
        PLAY_B = 3'd2,
        SD_A   = 3'd3,
        SD_B   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_a_q, score_a_d;
    logic [SCORE_W-1:0] score_b_q, score_b_d;
    logic [SCORE_W-1:0] round_q, round_d;
    logic               turn_q, turn_d;
    logic               sudden_q, sudden_d;
    logic               game_over_q, game_over_d;
    logic [1:0]         winner_q, winner_d;
    logic [2:0]         n_q, n_d;
    logic [2:0]         kicks_a_q, kicks_a_d;
    logic [2:0]         kicks_b_q, kicks_b_d;
    logic               sd_a_q, sd_a_d;

    // Saturating +1 shared by scores and round counter.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] x);
        return (&x) ? x : x + SCORE_W'(1);
    endfunction

    logic [SCORE_W-1:0] sa_plus, sb_plus;
    logic [2:0]         ka_plus, kb_plus;
    logic [SCORE_W-1:0] chk_sa, chk_sb;
    logic [2:0]         chk_ka, chk_kb;
    logic [W1-1:0]      rem_a, rem_b;
    logic               a_wins, b_wins;

    // Post-kick values and the early-decision test; the operands are picked
    // by which team is kicking so the check always sees the updated tally.
    always_comb begin
        sa_plus = goal_i ? sat_inc(score_a_q) : score_a_q;
        sb_plus = goal_i ? sat_inc(score_b_q) : score_b_q;
        ka_plus = kicks_a_q + 3'd1;
        kb_plus = kicks_b_q + 3'd1;
        chk_sa  = score_a_q;
        chk_sb  = score_b_q;
        chk_ka  = kicks_a_q;
        chk_kb  = kicks_b_q;
        if (state_q == PLAY_A) begin
            chk_sa = sa_plus;
            chk_ka = ka_plus;
        end else begin
            chk_sb = sb_plus;
            chk_kb = kb_plus;
        end
        rem_a  = W1'(n_q) - W1'(chk_ka);
        rem_b  = W1'(n_q) - W1'(chk_kb);
        a_wins = W1'(chk_sa) > (W1'(chk_sb) + rem_b);
        b_wins = W1'(chk_sb) > (W1'(chk_sa) + rem_a);
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        score_a_d   = score_a_q;
        score_b_d   = score_b_q;
        round_d     = round_q;
        turn_d      = turn_q;
        sudden_d    = sudden_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        n_d         = n_q;
        kicks_a_d   = kicks_a_q;
        kicks_b_d   = kicks_b_q;
        sd_a_d      = sd_a_q;
        case (state_q)
            IDLE, DONE: begin
                if (start3_i ^ start5_i) begin
                    n_d         = start3_i ? 3'd3 : 3'd5;
                    score_a_d   = '0;
                    score_b_d   = '0;
                    winner_d    = 2'b00;
                    round_d     = SCORE_W'(1);
                    turn_d      = 1'b0;
                    kicks_a_d   = 3'd0;
                    kicks_b_d   = 3'd0;
                    sudden_d    = 1'b0;
                    game_over_d = 1'b0;
                    state_d     = PLAY_A;
                end
            end
            PLAY_A: begin
                if (kick_i) begin
                    kicks_a_d = ka_plus;
                    score_a_d = sa_plus;
                    if (a_wins) begin
                        winner_d    = 2'b01;
                        game_over_d = 1'b1;
                        state_d     = DONE;
                    end else if (b_wins) begin
                        winner_d    = 2'b10;
                        game_over_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        turn_d  = 1'b1;
                        state_d = PLAY_B;
                    end
                end
            end
            PLAY_B: begin
                if (kick_i) begin
                    kicks_b_d = kb_plus;
                    score_b_d = sb_plus;
                    if (a_wins) begin
                        winner_d    = 2'b01;
                        game_over_d = 1'b1;
                        state_d     = DONE;
                    end else if (b_wins) begin
                        winner_d    = 2'b10;
                        game_over_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        round_d = sat_inc(round_q);
                        turn_d  = 1'b0;
                        if (kb_plus == n_q && score_a_q == sb_plus) begin
                            sudden_d = 1'b1;
                            state_d  = SD_A;
                        end else begin
                            state_d  = PLAY_A;
                        end
                    end
                end
            end
            SD_A: begin
                if (kick_i) begin
                    score_a_d = sa_plus;
                    sd_a_d    = goal_i;
                    turn_d    = 1'b1;
                    state_d   = SD_B;
                end
            end
            SD_B: begin
                if (kick_i) begin
                    score_b_d = sb_plus;
                    if (sd_a_q != goal_i) begin
                        winner_d    = sd_a_q ? 2'b01 : 2'b10;
                        game_over_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        round_d = sat_inc(round_q);
                        turn_d  = 1'b0;
                        state_d = SD_A;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single register bank for state and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            score_a_q   <= '0;
            score_b_q   <= '0;
            round_q     <= '0;
            turn_q      <= 1'b0;
            sudden_q    <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 2'b00;
            n_q         <= 3'd0;
            kicks_a_q   <= 3'd0;
            kicks_b_q   <= 3'd0;
            sd_a_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_a_q   <= score_a_d;
            score_b_q   <= score_b_d;
            round_q     <= round_d;
            turn_q      <= turn_d;
            sudden_q    <= sudden_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            n_q         <= n_d;
            kicks_a_q   <= kicks_a_d;
            kicks_b_q   <= kicks_b_d;
            sd_a_q      <= sd_a_d;
        end
    end

    assign score_a_o   = score_a_q;
    assign score_b_o   = score_b_q;
    assign turn_o      = turn_q;
    assign round_o     = round_q;
    assign sudden_o    = sudden_q;
    assign game_over_o = game_over_q;
    assign winner_o    = winner_q;

endmodule

// File: tb/tb_penalty_referee.sv
// Directed bench for penalty_referee with hand-derived expected values.
module tb_penalty_referee;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start3_i = 1'b0;
    logic       start5_i = 1'b0;
    logic       kick_i = 1'b0;
    logic       goal_i = 1'b0;
    logic [3:0] score_a_o, score_b_o, round_o;
    logic       turn_o, sudden_o, game_over_o;
    logic [1:0] winner_o;

    int total = 0;
    int bad   = 0;

    penalty_referee #(.SCORE_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start3_i    (start3_i),
        .start5_i    (start5_i),
        .kick_i      (kick_i),
        .goal_i      (goal_i),
        .score_a_o   (score_a_o),
        .score_b_o   (score_b_o),
        .turn_o      (turn_o),
        .round_o     (round_o),
        .sudden_o    (sudden_o),
        .game_over_o (game_over_o),
        .winner_o    (winner_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Snapshot of every output: score_a, score_b, round, turn, sudden, game_over, winner.
    task automatic chk_all(input string tag, input int sa, input int sb, input int rnd,
                           input int trn, input int sd, input int go, input int win);
        chk({tag, ".score_a"}, int'(score_a_o), sa);
        chk({tag, ".score_b"}, int'(score_b_o), sb);
        chk({tag, ".round"}, int'(round_o), rnd);
        chk({tag, ".turn"}, int'(turn_o), trn);
        chk({tag, ".sudden"}, int'(sudden_o), sd);
        chk({tag, ".game_over"}, int'(game_over_o), go);
        chk({tag, ".winner"}, int'(winner_o), win);
    endtask

    task automatic start(input logic s3, input logic s5);
        @(negedge clk);
        start3_i = s3;
        start5_i = s5;
        @(negedge clk);
        start3_i = 1'b0;
        start5_i = 1'b0;
    endtask

    task automatic do_kick(input logic g);
        @(negedge clk);
        kick_i = 1'b1;
        goal_i = g;
        @(negedge clk);
        kick_i = 1'b0;
        goal_i = 1'b0;
    endtask

    initial begin
        #2;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Kick in IDLE and a simultaneous double start are both ignored.
        do_kick(1'b1);
        chk_all("idle_kick", 0, 0, 0, 0, 0, 0, 0);
        start(1'b1, 1'b1);
        chk_all("double_start", 0, 0, 0, 0, 0, 0, 0);

        // 3-round game, single-edge latency of the first kick.
        start(1'b1, 1'b0);
        chk_all("start3", 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        kick_i = 1'b1;
        goal_i = 1'b1;
        @(posedge clk);
        #1;
        chk("latency.score_a", int'(score_a_o), 1);
        chk("latency.turn", int'(turn_o), 1);
        @(negedge clk);
        kick_i = 1'b0;
        goal_i = 1'b1;
        @(negedge clk);
        goal_i = 1'b0;
        @(negedge clk);
        chk_all("goal_no_kick", 1, 0, 1, 1, 0, 0, 0);

        // Early win for A: A g, B m, A g, B m -> decided after B's 2nd kick.
        do_kick(1'b0);
        chk_all("early.r2", 1, 0, 2, 0, 0, 0, 0);
        do_kick(1'b1);
        chk_all("early.a2", 2, 0, 2, 1, 0, 0, 0);
        do_kick(1'b0);
        chk_all("early.win", 2, 0, 2, 1, 0, 1, 1);
        do_kick(1'b1);
        chk_all("done_kick", 2, 0, 2, 1, 0, 1, 1);

        // Restart from DONE with start3, then all goals into sudden death.
        start(1'b1, 1'b0);
        chk_all("restart3", 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) do_kick(1'b1);
        chk_all("sd.enter", 3, 3, 4, 0, 1, 0, 0);
        do_kick(1'b1);
        chk_all("sd.r4a", 4, 3, 4, 1, 1, 0, 0);
        do_kick(1'b1);
        chk_all("sd.r4b", 4, 4, 5, 0, 1, 0, 0);
        do_kick(1'b0);
        chk_all("sd.r5a", 4, 4, 5, 1, 1, 0, 0);
        do_kick(1'b1);
        chk_all("sd.win_b", 4, 5, 5, 1, 1, 1, 2);

        // 5-round game; start5 mid-game is ignored.
        start(1'b0, 1'b1);
        chk_all("start5", 0, 0, 1, 0, 0, 0, 0);
        do_kick(1'b1);
        do_kick(1'b1);
        chk_all("g5.r1", 1, 1, 2, 0, 0, 0, 0);
        start(1'b0, 1'b1);
        chk_all("g5.start_ignored", 1, 1, 2, 0, 0, 0, 0);
        do_kick(1'b0);
        do_kick(1'b1);
        do_kick(1'b1);
        do_kick(1'b0);
        chk_all("g5.r3", 2, 2, 4, 0, 0, 0, 0);
        do_kick(1'b0);
        do_kick(1'b1);
        chk_all("g5.r4", 2, 3, 5, 0, 0, 0, 0);
        // A's 5th miss leaves A unable to catch up: B wins at once.
        do_kick(1'b0);
        chk_all("g5.a5", 2, 3, 5, 0, 0, 1, 2);
        do_kick(1'b1);
        chk_all("g5.b5_ignored", 2, 3, 5, 0, 0, 1, 2);

        // Saturation: sudden death of all goals pins round and scores at 15.
        start(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) do_kick(1'b1);
        for (int i = 0; i < 14; i++) begin
            do_kick(1'b1);
            do_kick(1'b1);
        end
        chk_all("sat", 15, 15, 15, 0, 1, 0, 0);
        do_kick(1'b0);
        do_kick(1'b1);
        chk_all("sat.win_b", 15, 15, 15, 1, 1, 1, 2);

        // Reset mid-game in PLAY_B with score_a=2.
        start(1'b1, 1'b0);
        do_kick(1'b1);
        do_kick(1'b0);
        do_kick(1'b1);
        chk_all("pre_rst", 2, 0, 2, 1, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        do_kick(1'b1);
        chk_all("post_rst_kick", 0, 0, 0, 0, 0, 0, 0);
        start(1'b0, 1'b1);
        chk_all("post_rst_start", 0, 0, 1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
